// File: rtl/count9999_pkg.sv
// Shared constants and the 7-segment decoder for the four-digit BCD counter.
package count9999_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned SCAN_W     = 16;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

   // BCD digit to active-low segments; non-BCD codes show blank
   function automatic logic [SEG_W-1:0] seg7_decode(input logic [DIGIT_W-1:0] digit);
      logic [SEG_W-1:0] seg;
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: up/down with wrap, carry/borrow out, sync clear.
module bcd_digit
   import count9999_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   input  logic               down,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry_c
);

   logic [DIGIT_W-1:0] next_digit_c;

   // Next value and carry/borrow; a non-BCD code recovers to 0 without carrying
   always_comb begin
      next_digit_c = digit;
      carry_c      = 1'b0;
      if (digit > DIGIT_W'(9)) begin
         next_digit_c = '0;
      end else if (down) begin
         if (digit == '0) begin
            next_digit_c = DIGIT_W'(9);
            carry_c      = en;
         end else begin
            next_digit_c = digit - DIGIT_W'(1);
         end
      end else begin
         if (digit == DIGIT_W'(9)) begin
            next_digit_c = '0;
            carry_c      = en;
         end else begin
            next_digit_c = digit + DIGIT_W'(1);
         end
      end
   end

   // Digit register: clear beats enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        digit <= '0;
      else if (clear) digit <= '0;
      else if (en)    digit <= next_digit_c;
   end

endmodule

// File: rtl/count9999_bcd.sv
// Four-digit BCD event counter with multiplexed common-anode 7-segment driver.
module count9999_bcd
   import count9999_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd40000,
   parameter logic        LZB      = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tc_1s,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        down,
   output logic [15:0] count_bcd,
   output logic        running,
   output logic        rollover,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
   logic [NUM_DIGITS-1:0]              carry_c;
   logic [NUM_DIGITS-1:0]              en_c;
   logic                               tick_en_c;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         scan_idx;
   logic               scan_active;
   logic               scan_tc_c;
   logic [DIGIT_W-1:0] sel_digit_c;
   logic               blank_c;
   logic [SEG_W-1:0]   seg_c;

   // A tick counts only against the run state held before any toggle this cycle
   assign tick_en_c = tc_1s & running & ~clear;
   assign en_c      = {carry_c[NUM_DIGITS-2:0], tick_en_c};
   assign count_bcd = digits;
   assign dp_n      = 1'b1;

   // Decade chain: each digit advances on the carry/borrow of the one below
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .rst     (rst),
         .clear   (clear),
         .en      (en_c[i]),
         .down    (down),
         .digit   (digits[i]),
         .carry_c (carry_c[i])
      );
   end

   // Run state toggle and one-cycle rollover from the top-digit carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running  <= 1'b0;
         rollover <= 1'b0;
      end else begin
         running  <= running ^ start_stop;
         rollover <= carry_c[NUM_DIGITS-1];
      end
   end

   assign scan_tc_c = (scan_cnt == SCAN_DIV - 16'd1);

   // Free-running scan timer; the first terminal count opens digit 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt    <= '0;
         scan_idx    <= '0;
         scan_active <= 1'b0;
      end else if (scan_tc_c) begin
         scan_cnt    <= '0;
         scan_active <= 1'b1;
         scan_idx    <= scan_active ? scan_idx + 2'd1 : 2'd0;
      end else begin
         scan_cnt    <= scan_cnt + SCAN_W'(1);
      end
   end

   // Digit select plus leading-zero blanking of the upper three digits
   always_comb begin
      sel_digit_c = digits[scan_idx];
      blank_c     = 1'b0;
      case (scan_idx)
         2'd3:    blank_c = LZB & (digits[3] == '0);
         2'd2:    blank_c = LZB & (digits[3] == '0) & (digits[2] == '0);
         2'd1:    blank_c = LZB & (digits[3] == '0) & (digits[2] == '0) & (digits[1] == '0);
         default: blank_c = 1'b0;
      endcase
      seg_c = blank_c ? SEG_BLANK : seg7_decode(sel_digit_c);
   end

   // Anode and segment registers load together so they never skew
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_n  <= 4'b1111;
         seg_n <= SEG_BLANK;
      end else if (scan_active) begin
         an_n  <= ~(4'b0001 << scan_idx);
         seg_n <= seg_c;
      end else begin
         an_n  <= 4'b1111;
         seg_n <= SEG_BLANK;
      end
   end

endmodule
